// File: rtl/fp_rf_pkg.sv
// Shared constants and helpers for the RV32F register file with scoreboard.
package fp_rf_pkg;

  localparam int FLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [FLEN_DEF-1:0] fp_word_t;

  // Address width for a register count. Clamped to 1 so a tiny file still has an address bit.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/fp_rf_scoreboard.sv
// Busy-bit scoreboard for long-latency FP results (FDIV/FSQRT).
// Priority per register: flush, then issue (set), then long-latency writeback (clear).
module fp_rf_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Per-register next state; an issue beats a same-cycle clear, flush beats both.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      assign busy_next[gi] = flush                                     ? 1'b0 :
                             (issue_en && (issue_rd == AW'(gi)))       ? 1'b1 :
                             (clr_en   && (clr_addr == AW'(gi)))       ? 1'b0 :
                                                                         busy_reg[gi];
    end
  endgenerate

  // Busy register; inputs are ignored while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

endmodule

// File: rtl/fp_regfile_sb.sv
// RV32F floating-point register file: NREAD combinational read ports, a pipeline
// writeback port (wr0) and a long-latency writeback port (wr1), with busy tracking,
// optional same-cycle write-to-read bypass and skipping of writes that would not
// change the stored value.
module fp_regfile_sb
  import fp_rf_pkg::*;
#(
  parameter int FLEN   = FLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 3,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*FLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr0_en,
  input  logic [AW-1:0]         wr0_addr,
  input  logic [FLEN-1:0]       wr0_data,
  input  logic                  wr1_en,
  input  logic [AW-1:0]         wr1_addr,
  input  logic [FLEN-1:0]       wr1_data,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec,
  output logic                  wr_collide,
  output logic                  wr_suppressed
);

  logic [FLEN-1:0] mem_reg [NREGS];
  logic            wr_collide_reg;
  logic            wr_suppressed_reg;

  logic wr0_same;
  logic wr1_same;
  logic collide_now;
  logic wr0_do;
  logic wr1_do;

  // A write whose data already matches the array is skipped; on a same-address
  // dual write port 0 owns the location, so port 1 never touches the array.
  always_comb begin
    wr0_same    = (wr0_data == mem_reg[wr0_addr]);
    wr1_same    = (wr1_data == mem_reg[wr1_addr]);
    collide_now = wr0_en && wr1_en && (wr0_addr == wr1_addr);
    wr0_do      = wr0_en && !wr0_same;
    wr1_do      = wr1_en && !wr1_same && !collide_now;
  end

  // Storage array plus the one-cycle collision/suppression pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_reg[r] <= '0;
      end
      wr_collide_reg    <= 1'b0;
      wr_suppressed_reg <= 1'b0;
    end else begin
      if (wr0_do) mem_reg[wr0_addr] <= wr0_data;
      if (wr1_do) mem_reg[wr1_addr] <= wr1_data;
      wr_collide_reg    <= collide_now;
      wr_suppressed_reg <= (wr0_en && wr0_same) || (wr1_en && wr1_same);
    end
  end

  assign wr_collide    = wr_collide_reg;
  assign wr_suppressed = wr_suppressed_reg;

  fp_rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .clr_en   (wr1_en),
    .clr_addr (wr1_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  // Read ports: busy is never bypassed; data optionally forwards wr0 then wr1.
  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr        = rd_addr[gi*AW +: AW];
      assign rd_busy[gi] = busy_vec[addr];
      if (BYPASS != 0) begin : g_byp
        assign rd_data[gi*FLEN +: FLEN] = (wr0_en && (wr0_addr == addr)) ? wr0_data :
                                          (wr1_en && (wr1_addr == addr)) ? wr1_data :
                                                                           mem_reg[addr];
      end else begin : g_nobyp
        assign rd_data[gi*FLEN +: FLEN] = mem_reg[addr];
      end
    end
  endgenerate

  // A pipeline write to a register still awaiting a long-latency result is a WAW hazard.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(wr0_en && busy_vec[wr0_addr]));
    end
  end

endmodule
